iter_multiplier: RTL and testbench
==================================

# iter_multiplier

Radix-2 shift-add multiplier serving the execute stage's HI/LO result path for MULT/MULTU. It captures the two forwarded execute-stage operands on a start pulse, iterates for WIDTH cycles and then presents a full-width product. The execute-stage output mux selects between the product's low and high halves. The hazard unit consumes `ready` and `done` to stall fetch/decode while a multiply is in flight.

## Interface
- WIDTH, 32: operand width; the product is 2*WIDTH bits wide.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous, active-high.
- start  input  1  request a multiply; sampled only while `ready`=1.
- sign  input  1  operand interpretation, sampled with `start`: 1 = two's complement (MULT), 0 = unsigned (MULTU).
- a  input  WIDTH  multiplicand, sampled with `start`.
- b  input  WIDTH  multiplier, sampled with `start`.
- ready  output  1  high in IDLE; the unit accepts `start`.
- done  output  1  one-cycle pulse; `product` is updated and valid.
- product  output  2*WIDTH  registered result; holds its value until the next completion or reset.

## Operation
- States:
  - IDLE: `ready`=1, `done`=0.
  - BUSY: WIDTH iterations, `ready`=0, `done`=0.
  - DONE: `ready`=0, `done`=1.
- Transitions:
  - IDLE with `start`=1 → BUSY.
  - BUSY → DONE after WIDTH iterations.
  - DONE → IDLE unconditionally.
- Operand capture on entry to BUSY:
  - Store the magnitudes |a| and |b| when `sign`=1. Magnitudes are taken as unsigned WIDTH-bit values, so 0x8000_0000 has magnitude 0x8000_0000.
  - Store the raw operands when `sign`=0.
  - Latch `neg` = `sign` & (a[WIDTH-1] ^ b[WIDTH-1]).
- Each BUSY iteration:
  - If the multiplier LSB is 1, add the multiplicand (zero-extended to 2*WIDTH) into the 2*WIDTH accumulator.
  - Shift the multiplicand left by 1 and the multiplier right by 1.
  - A 6-bit counter (clog2(WIDTH)+1 bits) counts iterations 0..WIDTH-1.
- On the final iteration's edge, `product` is loaded with the accumulator, two's-complement negated over 2*WIDTH bits when `neg`=1.
  - A zero result stays zero even when `neg`=1.
- `start` while `ready`=0 (BUSY or DONE) is ignored: no queuing and no restart.
- Changes on a/b/sign after capture do not affect the result in flight.

## Timing
- Reset (synchronous, checked before every other update): state=IDLE, `ready`=1, `done`=0, `product`=0, accumulator/counter/`neg`=0.
- Reset asserted mid-operation aborts the operation. The next cycle is IDLE with `product`=0, and `done` is never pulsed for the aborted operation.
- Latency:
  - Edge E0 samples `start`=1 with `ready`=1 → BUSY.
  - Edges E1..E_WIDTH perform the iterations; E_WIDTH also writes `product`.
  - `done`=1 during the cycle after E_WIDTH.
  - Edge E_WIDTH+1 → IDLE, `ready`=1.
  - Total: WIDTH+2 cycles from start acceptance to the next possible acceptance.
- `product` changes only on the edge that enters DONE. It is stable on every other edge.
- `start` held high continuously produces back-to-back operations, one per WIDTH+2 cycles.
- `start` coincident with `reset` is ignored.

## Test plan
- Unsigned, WIDTH=32: a=0xFFFF_FFFF, b=0xFFFF_FFFF, sign=0 → `done` at cycle 33 after acceptance; product=0xFFFF_FFFE_0000_0001; `ready`=1 at cycle 34.
- Signed mixed: a=-3 (0xFFFF_FFFD), b=7, sign=1 → product=0xFFFF_FFFF_FFFF_FFEB (-21). The same operands with sign=0 → product=0x0000_0006_FFFF_FFEB.
- Signed extremes: a=b=0x8000_0000, sign=1 → product=0x4000_0000_0000_0000. a=0x8000_0000, b=1, sign=1 → 0xFFFF_FFFF_8000_0000.
- Zero and sign: a=0, b=-5, sign=1 → product=0, with no negative zero. Drive `start` pulses during BUSY and DONE → ignored; exactly one `done` pulse occurs.
- Reset mid-operation: start a=6, b=7; assert `reset` at iteration 10 → next cycle `ready`=1, `product`=0, no `done`. A fresh start with a=6, b=7 → product=42.
- Back-to-back: hold `start`=1 with a=2, b=3 then a=4, b=5 → `done` pulses are spaced 34 cycles apart; product reads 6 then 20. Operand changes during BUSY do not alter the in-flight result.

Source files
------------

// File: rtl/iter_multiplier.sv
// Radix-2 shift-add multiplier for MULT/MULTU: captures operands on start,
// iterates WIDTH cycles, then pulses done with a registered 2*WIDTH product.
module iter_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               sign,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               ready,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state, state_next;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [CW-1:0]      cnt;
  logic               neg;
  logic               last_iter;

  // Magnitudes are plain unsigned WIDTH-bit values, so the most negative input maps to itself.
  assign mag_a     = (sign && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
  assign mag_b     = (sign && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
  assign acc_next  = mplier[0] ? (acc + mcand) : acc;
  assign last_iter = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    ready      = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_next = BUSY;
      end
      BUSY: begin
        if (last_iter) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath; product is written only on the edge that finishes the last iteration.
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
      neg     <= 1'b0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= {{WIDTH{1'b0}}, mag_a};
            mplier <= mag_b;
            acc    <= '0;
            cnt    <= '0;
            neg    <= sign & (a[WIDTH-1] ^ b[WIDTH-1]);
          end
        end
        BUSY: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          // Negating zero yields zero, so no special case is needed for -0.
          if (last_iter)
            product <= neg ? (~acc_next + (2*WIDTH)'(1)) : acc_next;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_multiplier.sv
// Directed-vector bench for iter_multiplier (WIDTH=32) with hand-computed products.
module tb_iter_multiplier;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        sign;
  logic [31:0] a;
  logic [31:0] b;
  logic        ready;
  logic        done;
  logic [63:0] product;

  int vectors     = 0;
  int miscompares = 0;

  iter_multiplier #(.WIDTH(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .sign    (sign),
    .a       (a),
    .b       (b),
    .ready   (ready),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  // Starts one operation from IDLE and returns the cycle at which done was seen.
  task automatic do_op(input logic [31:0] ia, input logic [31:0] ib, input logic is,
                       output int cycles);
    a = ia; b = ib; sign = is; start = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    cycles = 1;
    while (done !== 1'b1 && cycles < 100) begin
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b1; sign = 1'b0; a = 32'd5; b = 32'd5;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b0; reset = 1'b0;
    vectors++; if (ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_ready got %b exp 1", ready); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done got %b exp 0", done); end
    vectors++; if (product !== 64'd0) begin miscompares++; $display("[TB] FAIL reset_product got %h exp 0", product); end
    @(posedge clk); #1;
    vectors++; if (ready !== 1'b1) begin miscompares++; $display("[TB] FAIL start_with_reset_ignored ready got %b exp 1", ready); end
  endtask

  task automatic test_unsigned;
    int cyc;
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, cyc);
    vectors++; if (cyc !== 33) begin miscompares++; $display("[TB] FAIL unsigned_latency got %0d exp 33", cyc); end
    vectors++; if (product !== 64'hFFFF_FFFE_0000_0001) begin miscompares++; $display("[TB] FAIL unsigned_max got %h exp fffffffe00000001", product); end
    vectors++; if (ready !== 1'b0) begin miscompares++; $display("[TB] FAIL ready_in_done got %b exp 0", ready); end
    @(posedge clk); #1;
    vectors++; if (ready !== 1'b1) begin miscompares++; $display("[TB] FAIL ready_at_34 got %b exp 1", ready); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL done_one_cycle got %b exp 0", done); end
  endtask

  task automatic test_signed_mixed;
    int cyc;
    do_op(32'hFFFF_FFFD, 32'd7, 1'b1, cyc);
    vectors++; if (product !== 64'hFFFF_FFFF_FFFF_FFEB) begin miscompares++; $display("[TB] FAIL signed_m3x7 got %h exp ffffffffffffffeb", product); end
    @(posedge clk); #1;
    do_op(32'hFFFF_FFFD, 32'd7, 1'b0, cyc);
    vectors++; if (product !== 64'h0000_0006_FFFF_FFEB) begin miscompares++; $display("[TB] FAIL unsigned_m3x7 got %h exp 00000006ffffffeb", product); end
    @(posedge clk); #1;
  endtask

  task automatic test_signed_extremes;
    int cyc;
    do_op(32'h8000_0000, 32'h8000_0000, 1'b1, cyc);
    vectors++; if (product !== 64'h4000_0000_0000_0000) begin miscompares++; $display("[TB] FAIL min_x_min got %h exp 4000000000000000", product); end
    @(posedge clk); #1;
    do_op(32'h8000_0000, 32'd1, 1'b1, cyc);
    vectors++; if (product !== 64'hFFFF_FFFF_8000_0000) begin miscompares++; $display("[TB] FAIL min_x_1 got %h exp ffffffff80000000", product); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    int cyc;
    int dones;
    a = 32'd6; b = 32'd7; sign = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    vectors++; if (ready !== 1'b1) begin miscompares++; $display("[TB] FAIL abort_ready got %b exp 1", ready); end
    vectors++; if (product !== 64'd0) begin miscompares++; $display("[TB] FAIL abort_product got %h exp 0", product); end
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) dones++;
      @(posedge clk); #1;
    end
    vectors++; if (dones !== 0) begin miscompares++; $display("[TB] FAIL abort_no_done got %0d exp 0", dones); end
    do_op(32'd6, 32'd7, 1'b0, cyc);
    vectors++; if (product !== 64'd42) begin miscompares++; $display("[TB] FAIL after_abort got %h exp 42", product); end
    vectors++; if (cyc !== 33) begin miscompares++; $display("[TB] FAIL after_abort_latency got %0d exp 33", cyc); end
    @(posedge clk); #1;
  endtask

  task automatic test_zero_ignored_start;
    int t;
    int dones;
    a = 32'd0; b = 32'hFFFF_FFFB; sign = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    t = 1; dones = 0;
    while (t < 80) begin
      if (done === 1'b1) begin
        dones++;
        vectors++; if (product !== 64'd0) begin miscompares++; $display("[TB] FAIL zero_neg got %h exp 0", product); end
      end
      // Stray starts with different operands while busy and while done.
      start = (t == 5 || t == 20 || done === 1'b1);
      a = 32'd6; b = 32'd7; sign = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      t++;
    end
    vectors++; if (dones !== 1) begin miscompares++; $display("[TB] FAIL ignored_start_dones got %0d exp 1", dones); end
    vectors++; if (product !== 64'd0) begin miscompares++; $display("[TB] FAIL ignored_start_product got %h exp 0", product); end
    vectors++; if (ready !== 1'b1) begin miscompares++; $display("[TB] FAIL ignored_start_ready got %b exp 1", ready); end
  endtask

  task automatic test_back_to_back;
    int t;
    int dones;
    int t_first;
    int t_second;
    logic [63:0] p_first;
    logic [63:0] p_second;
    a = 32'd2; b = 32'd3; sign = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    a = 32'd4; b = 32'd5;
    t = 1; dones = 0; t_first = -1; t_second = -1; p_first = '1; p_second = '1;
    while (t <= 80) begin
      if (done === 1'b1) begin
        dones++;
        if (dones == 1) begin t_first = t; p_first = product; end
        if (dones == 2) begin t_second = t; p_second = product; end
      end
      if (t == 35) begin start = 1'b0; a = 32'd9; b = 32'd9; end
      if (t == 50) begin
        vectors++; if (product !== 64'd6) begin miscompares++; $display("[TB] FAIL product_hold got %h exp 6", product); end
      end
      @(posedge clk); #1;
      t++;
    end
    vectors++; if (t_first !== 33) begin miscompares++; $display("[TB] FAIL b2b_first_time got %0d exp 33", t_first); end
    vectors++; if (p_first !== 64'd6) begin miscompares++; $display("[TB] FAIL b2b_first_product got %h exp 6", p_first); end
    vectors++; if (t_second - t_first !== 34) begin miscompares++; $display("[TB] FAIL b2b_spacing got %0d exp 34", t_second - t_first); end
    vectors++; if (p_second !== 64'd20) begin miscompares++; $display("[TB] FAIL b2b_second_product got %h exp 20", p_second); end
    vectors++; if (dones !== 2) begin miscompares++; $display("[TB] FAIL b2b_done_count got %0d exp 2", dones); end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; sign = 1'b0; a = '0; b = '0;
    test_reset;
    test_unsigned;
    test_signed_mixed;
    test_signed_extremes;
    test_reset_mid;
    test_zero_ignored_start;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

endmodule
